// File: rtl/mpu_i2c_sequencer.sv
// MPU-6050 command sequencer: writes the configuration table once per reset, then
// loops six single-byte accelerometer reads and publishes signed X/Y/Z samples.
module mpu_i2c_sequencer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter int         TXN_CYCLES = 40,
  parameter int         GAP_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run,
  output logic               o_i2c_en,
  output logic [6:0]         o_i2c_slave_addr,
  output logic               o_i2c_rw,
  output logic [7:0]         o_i2c_reg_addr,
  output logic [7:0]         o_i2c_data,
  input  logic [7:0]         i_i2c_rdata,
  output logic signed [15:0] o_accel_x,
  output logic signed [15:0] o_accel_y,
  output logic signed [15:0] o_accel_z,
  output logic               o_sample_valid,
  output logic               o_init_done,
  output logic               o_busy
);

  localparam int CNT_MAX = (TXN_CYCLES > GAP_CYCLES) ? TXN_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  // ISSUE takes one cycle, so the wait covers the remaining TXN_CYCLES-1 cycles.
  localparam logic [CW-1:0] TXN_LAST = CW'(TXN_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_ISSUE, S_INIT_WAIT, S_RD_ISSUE, S_RD_WAIT, S_PUBLISH, S_GAP
  } state_t;

  function automatic logic [15:0] cfg_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    cfg_entry = {8'h6B, 8'h00};
      3'd1:    cfg_entry = {8'h19, 8'h07};
      3'd2:    cfg_entry = {8'h1A, 8'h06};
      3'd3:    cfg_entry = {8'h1B, 8'h00};
      3'd4:    cfg_entry = {8'h1C, 8'h00};
      default: cfg_entry = {8'h00, 8'h00};
    endcase
  endfunction

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [2:0]     r_idx, w_idx_next;
  logic [2:0]     r_byte_idx, w_byte_idx_next;
  logic           r_init_done, w_init_done_next;
  logic           r_en, w_en_next;
  logic           r_rw, w_rw_next;
  logic [7:0]     r_reg, w_reg_next;
  logic [7:0]     r_data, w_data_next;
  logic           r_valid, w_valid_next;
  logic           r_busy, w_busy_next;
  logic [15:0]    r_ax, r_ay, r_az, w_ax_next, w_ay_next, w_az_next;
  logic [7:0]     r_shadow [5];
  logic           w_shadow_we;
  logic [15:0]    w_cfg;

  // Next-state, counters and registered-output values.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_idx_next       = r_idx;
    w_byte_idx_next  = r_byte_idx;
    w_init_done_next = r_init_done;
    w_en_next        = 1'b0;
    w_rw_next        = r_rw;
    w_reg_next       = r_reg;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_ax_next        = r_ax;
    w_ay_next        = r_ay;
    w_az_next        = r_az;
    w_shadow_we      = 1'b0;
    w_cfg            = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_next = r_init_done ? S_RD_ISSUE : S_INIT_ISSUE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_INIT_ISSUE: begin
        w_state_next = S_INIT_WAIT;
        w_cnt_next   = CNT_ZERO;
      end
      S_INIT_WAIT: begin
        if (r_cnt == TXN_LAST) begin
          w_cnt_next = CNT_ZERO;
          if (r_idx == 3'd4) begin
            w_init_done_next = 1'b1;
            w_idx_next       = 3'd0;
            w_state_next     = i_run ? S_RD_ISSUE : S_IDLE;
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_state_next = S_INIT_ISSUE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_RD_ISSUE: begin
        w_state_next = S_RD_WAIT;
        w_cnt_next   = CNT_ZERO;
      end
      S_RD_WAIT: begin
        if (r_cnt == TXN_LAST) begin
          w_cnt_next = CNT_ZERO;
          if (r_byte_idx == 3'd5) begin
            // The last byte bypasses the shadow so samples appear with the strobe.
            w_state_next = S_PUBLISH;
            w_valid_next = 1'b1;
            w_ax_next    = {r_shadow[0], r_shadow[1]};
            w_ay_next    = {r_shadow[2], r_shadow[3]};
            w_az_next    = {r_shadow[4], i_i2c_rdata};
          end else begin
            w_shadow_we     = 1'b1;
            w_byte_idx_next = r_byte_idx + 3'd1;
            w_state_next    = S_RD_ISSUE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_PUBLISH: begin
        w_byte_idx_next = 3'd0;
        w_cnt_next      = CNT_ZERO;
        w_state_next    = i_run ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (!i_run) begin
          w_cnt_next   = CNT_ZERO;
          w_state_next = S_IDLE;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_next   = CNT_ZERO;
          w_state_next = S_RD_ISSUE;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = CNT_ZERO;
      end
    endcase

    if (w_state_next == S_INIT_ISSUE) begin
      w_cfg       = cfg_entry(w_idx_next);
      w_en_next   = 1'b1;
      w_rw_next   = 1'b0;
      w_reg_next  = w_cfg[15:8];
      w_data_next = w_cfg[7:0];
    end else if (w_state_next == S_RD_ISSUE) begin
      w_en_next   = 1'b1;
      w_rw_next   = 1'b1;
      w_reg_next  = 8'h3B + {5'b00000, w_byte_idx_next};
    end else begin
      w_en_next   = 1'b0;
    end
    w_busy_next = (w_state_next != S_IDLE) && (w_state_next != S_GAP);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_idx       <= 3'd0;
      r_byte_idx  <= 3'd0;
      r_init_done <= 1'b0;
      r_en        <= 1'b0;
      r_rw        <= 1'b0;
      r_reg       <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_ax        <= 16'h0000;
      r_ay        <= 16'h0000;
      r_az        <= 16'h0000;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_byte_idx  <= w_byte_idx_next;
      r_init_done <= w_init_done_next;
      r_en        <= w_en_next;
      r_rw        <= w_rw_next;
      r_reg       <= w_reg_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_busy      <= w_busy_next;
      r_ax        <= w_ax_next;
      r_ay        <= w_ay_next;
      r_az        <= w_az_next;
    end
  end

  // Shadow bytes 0..4 of the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        r_shadow[i] <= 8'h00;
      end
    end else if (w_shadow_we) begin
      r_shadow[r_byte_idx] <= i_i2c_rdata;
    end
  end

  assign o_i2c_en         = r_en;
  assign o_i2c_slave_addr = SLAVE_ADDR;
  assign o_i2c_rw         = r_rw;
  assign o_i2c_reg_addr   = r_reg;
  assign o_i2c_data       = r_data;
  assign o_accel_x        = r_ax;
  assign o_accel_y        = r_ay;
  assign o_accel_z        = r_az;
  assign o_sample_valid   = r_valid;
  assign o_init_done      = r_init_done;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_mpu_i2c_sequencer.sv
// Scoreboard bench: stimulus queues expected I2C transactions and samples, a
// negedge monitor pops and compares them; a stub answers accelerometer reads.
module tb_mpu_i2c_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_run = 1'b0;
  logic [7:0]  i_i2c_rdata = 8'h00;
  logic        o_i2c_en, o_i2c_rw, o_sample_valid, o_init_done, o_busy;
  logic [6:0]  o_i2c_slave_addr;
  logic [7:0]  o_i2c_reg_addr, o_i2c_data;
  logic signed [15:0] o_accel_x, o_accel_y, o_accel_z;

  mpu_i2c_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run),
    .o_i2c_en(o_i2c_en), .o_i2c_slave_addr(o_i2c_slave_addr), .o_i2c_rw(o_i2c_rw),
    .o_i2c_reg_addr(o_i2c_reg_addr), .o_i2c_data(o_i2c_data), .i_i2c_rdata(i_i2c_rdata),
    .o_accel_x(o_accel_x), .o_accel_y(o_accel_y), .o_accel_z(o_accel_z),
    .o_sample_valid(o_sample_valid), .o_init_done(o_init_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [7:0] ra; logic [7:0] wd; int gap; } txn_t;
  typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] z; } smp_t;

  txn_t exp_txn_q[$];
  smp_t exp_smp_q[$];
  logic [7:0] stub_mem [6];
  int n_checks = 0, n_pass = 0;
  int n_en = 0, n_valid = 0;
  int cyc = 0, last_en = 0;
  logic prev_valid = 1'b0;
  txn_t t;
  smp_t s;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_write(input int gap, input logic [7:0] ra, input logic [7:0] wd);
    exp_txn_q.push_back('{rw: 1'b0, ra: ra, wd: wd, gap: gap});
  endtask

  task automatic push_init(input int gap0);
    push_write(gap0, 8'h6B, 8'h00);
    push_write(40,   8'h19, 8'h07);
    push_write(40,   8'h1A, 8'h06);
    push_write(40,   8'h1B, 8'h00);
    push_write(40,   8'h1C, 8'h00);
  endtask

  task automatic push_burst(input int gap0, input logic [47:0] bytes,
                            input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez);
    for (int i = 0; i < 6; i++) begin
      stub_mem[i] = bytes[47-8*i -: 8];
      exp_txn_q.push_back('{rw: 1'b1, ra: 8'h3B + 8'(i), wd: 8'h00, gap: (i == 0) ? gap0 : 40});
    end
    exp_smp_q.push_back('{x: ex, y: ey, z: ez});
  endtask

  task automatic wait_en(input int target, input int budget);
    int b = budget;
    while (n_en < target && b > 0) begin
      @(posedge clk);
      b--;
    end
    check("wait_en", 64'(n_en >= target), 64'd1);
  endtask

  task automatic wait_valid(input int target, input int budget);
    int b = budget;
    while (n_valid < target && b > 0) begin
      @(posedge clk);
      b--;
    end
    check("wait_valid", 64'(n_valid >= target), 64'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stub slave: serves the accelerometer byte for each read request.
  always @(negedge clk) begin
    if (o_i2c_en && o_i2c_rw && o_i2c_reg_addr >= 8'h3B && o_i2c_reg_addr <= 8'h40)
      i_i2c_rdata = stub_mem[int'(o_i2c_reg_addr) - 32'h3B];
  end

  // Monitor: compare every i2c_en and sample_valid against the scoreboard.
  always @(negedge clk) begin
    if (o_i2c_en) begin
      n_en++;
      if (exp_txn_q.size() == 0) begin
        check("unexpected_en", {o_i2c_rw, o_i2c_reg_addr}, 64'hDEAD);
      end else begin
        t = exp_txn_q.pop_front();
        check("txn", {o_i2c_slave_addr, o_i2c_rw, o_i2c_reg_addr, (t.rw ? 8'h00 : o_i2c_data)},
              {7'h68, t.rw, t.ra, t.wd});
        if (t.gap != 0) check("en_spacing", 64'(cyc - last_en), 64'(t.gap));
      end
      last_en = cyc;
    end
    if (o_sample_valid) begin
      n_valid++;
      check("valid_single", 64'(prev_valid), 64'd0);
      if (exp_smp_q.size() == 0) begin
        check("unexpected_valid", {o_accel_x, o_accel_y, o_accel_z}, 64'hDEAD);
      end else begin
        s = exp_smp_q.pop_front();
        check("sample", {o_accel_x, o_accel_y, o_accel_z}, {s.x, s.y, s.z});
      end
    end
    prev_valid = o_sample_valid;
  end

  initial begin
    int base;
    #12;
    check("reset_ctrl", {o_i2c_en, o_i2c_rw, o_i2c_reg_addr, o_i2c_data, o_sample_valid, o_init_done, o_busy}, 64'd0);
    check("reset_accel", {o_accel_x, o_accel_y, o_accel_z}, 64'd0);

    // Init then first sample.
    push_init(0);
    push_burst(40, 48'h1234_FFFE_4000, 16'h1234, 16'hFFFE, 16'h4000);
    @(negedge clk);
    rst_n = 1'b1;
    i_run = 1'b1;
    wait_en(5, 3000);
    repeat (38) @(posedge clk);
    #1 check("init_done_before", 64'(o_init_done), 64'd0);
    @(posedge clk);
    #1 check("init_done_rise", 64'(o_init_done), 64'd1);
    check("busy_reading", 64'(o_busy), 64'd1);
    wait_valid(1, 3000);

    // Periodic operation: next burst after the gap, samples held meanwhile.
    push_burst(1041, 48'h8000_7FFF_0001, 16'h8000, 16'h7FFF, 16'h0001);
    repeat (500) @(posedge clk);
    #1 check("hold_gap", {o_accel_x, o_accel_y, o_accel_z}, 64'h1234_FFFE_4000);
    check("busy_gap", 64'(o_busy), 64'd0);
    wait_valid(2, 3000);

    // run drop after the 3rd read: burst completes, then IDLE.
    push_burst(1041, 48'hA55A_0000_C33C, 16'hA55A, 16'h0000, 16'hC33C);
    base = n_en;
    wait_en(base + 3, 3000);
    #1 i_run = 1'b0;
    wait_valid(3, 3000);
    repeat (300) @(posedge clk);
    #1 check("busy_idle", 64'(o_busy), 64'd0);
    check("hold_idle", {o_accel_x, o_accel_y, o_accel_z}, 64'hA55A_0000_C33C);
    push_burst(0, 48'h0102_0304_0506, 16'h0102, 16'h0304, 16'h0506);
    i_run = 1'b1;
    base = n_en;
    wait_en(base + 1, 4);
    wait_valid(4, 3000);

    // run drop 10 clocks into GAP: IDLE next clock, reads restart at once.
    repeat (9) @(posedge clk);
    #1 i_run = 1'b0;
    push_burst(53, 48'hFEDC_BA98_7654, 16'hFEDC, 16'hBA98, 16'h7654);
    @(posedge clk);
    #1 check("busy_after_gap_drop", 64'(o_busy), 64'd0);
    @(posedge clk);
    #1 i_run = 1'b1;
    wait_valid(5, 3000);

    // Async reset mid-init: init restarts from the first table entry.
    #1 rst_n = 1'b0;
    push_write(0, 8'h6B, 8'h00);
    push_write(40, 8'h19, 8'h07);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_en;
    wait_en(base + 2, 3000);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_rst_ctrl", {o_i2c_en, o_i2c_rw, o_i2c_reg_addr, o_i2c_data, o_sample_valid, o_init_done, o_busy}, 64'd0);
    check("async_rst_accel", {o_accel_x, o_accel_y, o_accel_z}, 64'd0);
    push_init(0);
    push_burst(40, 48'h00FF_11EE_22DD, 16'h00FF, 16'h11EE, 16'h22DD);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_en;
    wait_en(base + 6, 3000);
    #1 i_run = 1'b0;
    wait_valid(6, 3000);
    repeat (20) @(posedge clk);
    #1 check("init_done_sticky", 64'(o_init_done), 64'd1);
    check("busy_final", 64'(o_busy), 64'd0);
    check("txn_q_empty", 64'(exp_txn_q.size()), 64'd0);
    check("smp_q_empty", 64'(exp_smp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
